// File: rtl/bnn_pkg.sv
// Shared constants and FSM encoding for the 8-8-4 BNN core and its programming path.
package bnn_pkg;

   localparam int NUM_NEURONS = 12;
   localparam int WEIGHT_W    = 8;
   localparam int NIBBLE_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LO    = 3'd3,
      ST_HI    = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/bnn_weight_loader.sv
// Converts a valid/ready byte stream into the BNN core's two-cycle nibble-serial
// load protocol, preceded by a pointer-rewind pulse and followed by done/checksum.
module bnn_weight_loader #(
   parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   output logic             load_en,
   output logic [3:0]       load_nibble,
   output logic             bnn_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] byte_count,
   output logic [7:0]       checksum
);
   import bnn_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NEURONS);

   state_t                  state_q, state_d;
   logic [WEIGHT_W-1:0]     byte_q, byte_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [7:0]              csum_q, csum_d;
   logic                    load_en_q, load_en_d;
   logic [NIBBLE_W-1:0]     nibble_q, nibble_d;
   logic                    bnn_rst_q, bnn_rst_d;
   logic                    more_bytes;
   logic                    take;

   assign more_bytes = (count_q < LAST_CNT);
   assign s_ready    = (state_q == ST_WAIT) || ((state_q == ST_HI) && more_bytes);
   // A start in the same cycle as a handshake wins; that byte is dropped.
   assign take       = s_valid && s_ready && !start;

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      count_d = count_q;
      csum_d  = csum_q;
      if (start) begin
         state_d = ST_CLEAR;
         count_d = '0;
         csum_d  = '0;
      end else begin
         case (state_q)
            ST_CLEAR: state_d = ST_WAIT;
            ST_WAIT:  if (take) state_d = ST_LO;
            ST_LO:    state_d = ST_HI;
            ST_HI: begin
               if (take)            state_d = ST_LO;
               else if (more_bytes) state_d = ST_WAIT;
               else                 state_d = ST_DONE;
            end
            default:  state_d = state_q;
         endcase
         if (take) begin
            byte_d  = s_data;
            count_d = count_q + 1'b1;
            csum_d  = csum_q + s_data;
         end
      end
   end

   // Core-facing pins are decoded from the next state so they leave a flop cleanly.
   always_comb begin
      load_en_d = (state_d == ST_LO) || (state_d == ST_HI);
      bnn_rst_d = (state_d == ST_CLEAR);
      nibble_d  = '0;
      if (state_d == ST_LO)      nibble_d = byte_d[3:0];
      else if (state_d == ST_HI) nibble_d = byte_d[7:4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         byte_q    <= '0;
         count_q   <= '0;
         csum_q    <= '0;
         load_en_q <= 1'b0;
         nibble_q  <= '0;
         bnn_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         count_q   <= count_d;
         csum_q    <= csum_d;
         load_en_q <= load_en_d;
         nibble_q  <= nibble_d;
         bnn_rst_q <= bnn_rst_d;
      end
   end

   assign load_en     = load_en_q;
   assign load_nibble = nibble_q;
   assign bnn_rst     = bnn_rst_q;
   assign busy        = (state_q == ST_CLEAR) || (state_q == ST_WAIT) ||
                        (state_q == ST_LO)    || (state_q == ST_HI);
   assign done        = (state_q == ST_DONE);
   assign byte_count  = count_q;
   assign checksum    = csum_q;

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Directed bench for bnn_weight_loader: vector table for the gapless load plus
// hand sequences for gaps, overflow, restart, checksum wrap and async reset.
module tb_bnn_weight_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready, load_en, bnn_rst, busy, done;
   logic [3:0] load_nibble;
   logic [3:0] byte_count;
   logic [7:0] checksum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bnn_weight_loader dut (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .load_en(load_en), .load_nibble(load_nibble), .bnn_rst(bnn_rst),
      .busy(busy), .done(done), .byte_count(byte_count), .checksum(checksum)
   );

   // packed expectation: {load_en, nibble, s_ready, bnn_rst, busy, done, count, checksum}
   function automatic logic [20:0] E(input logic le, input logic [3:0] nb, input logic rdy,
                                     input logic br, input logic bz, input logic dn,
                                     input logic [3:0] bc, input logic [7:0] cs);
      return {le, nb, rdy, br, bz, dn, bc, cs};
   endfunction

   task automatic chk(input string nm, input logic [20:0] exp);
      logic [20:0] act;
      act = {load_en, load_nibble, s_ready, bnn_rst, busy, done, byte_count, checksum};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {le,nib,rdy,rst,busy,done,cnt,csum}=%h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic st, input logic vl, input logic [7:0] d);
      @(negedge clk);
      start = st; s_valid = vl; s_data = d;
      @(posedge clk);
      #1;
   endtask

   // Core-side model: rebuilds bytes from nibble pairs and checks pairs are never split.
   int         run = 0;
   int         last_run = 0;
   logic [3:0] lo_nib;
   logic [7:0] got_q[$];
   always @(negedge clk) begin
      if (reset) run = 0;
      else if (load_en) begin
         if (run % 2 == 0) lo_nib = load_nibble;
         else got_q.push_back({load_nibble, lo_nib});
         run++;
      end else if (run != 0) begin
         total++;
         if (run % 2 != 0) begin
            bad++;
            $display("FAIL load_en_pairs: got run of %0d cycles, required an even run", run);
         end
         last_run = run;
         run = 0;
      end
   end

   typedef struct {
      logic        st;
      logic        vl;
      logic [7:0]  d;
      logic [20:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic st, input logic vl, input logic [7:0] d, input logic [20:0] exp);
      vec_t v;
      v.st = st; v.vl = vl; v.d = d; v.exp = exp;
      tbl.push_back(v);
   endtask

   logic [7:0] gb[12] = '{8'hE0, 8'h70, 8'h35, 8'h9A, 8'hC4, 8'h1F,
                          8'h08, 8'hB6, 8'h5D, 8'hF1, 8'h2C, 8'h83};
   logic [7:0] cs;

   initial begin
      // back-to-back table: bytes 0x00..0x0B, valid held high
      add(1, 0, 8'h00, E(0, 4'h0, 0, 1, 1, 0, 4'd0, 8'h00));
      add(0, 1, 8'h00, E(0, 4'h0, 1, 0, 1, 0, 4'd0, 8'h00));
      for (int k = 0; k < 12; k++) begin
         add(0, 1, 8'(k), E(1, 4'(k), 0, 0, 1, 0, 4'(k + 1), 8'(k * (k + 1) / 2)));
         add(0, 1, 8'(k), E(1, 4'h0, (k < 11), 0, 1, 0, 4'(k + 1), 8'(k * (k + 1) / 2)));
      end
      add(0, 0, 8'h00, E(0, 4'h0, 0, 0, 0, 1, 4'd12, 8'h42));

      #12;
      chk("reset_state", '0);
      @(negedge clk);
      reset = 1'b0;
      cyc(0, 1, 8'h33);
      chk("idle_no_accept", '0);

      foreach (tbl[i]) begin
         cyc(tbl[i].st, tbl[i].vl, tbl[i].d);
         chk($sformatf("b2b[%0d]", i), tbl[i].exp);
      end

      // overflow guard
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 8'hFF);
         chk($sformatf("overflow[%0d]", i), E(0, 4'h0, 0, 0, 0, 1, 4'd12, 8'h42));
      end
      total++;
      if (last_run != 24) begin
         bad++;
         $display("FAIL b2b_run_len: got %0d required 24", last_run);
      end

      // gapped load, 3 idle cycles between bytes
      got_q.delete();
      cs = 8'h00;
      cyc(1, 0, 8'h00);
      chk("gap_clear", E(0, 4'h0, 0, 1, 1, 0, 4'd0, 8'h00));
      cyc(0, 0, 8'h00);
      chk("gap_wait0", E(0, 4'h0, 1, 0, 1, 0, 4'd0, 8'h00));
      for (int k = 0; k < 12; k++) begin
         cs = cs + gb[k];
         cyc(0, 1, gb[k]);
         chk($sformatf("gap_lo[%0d]", k), E(1, gb[k][3:0], 0, 0, 1, 0, 4'(k + 1), cs));
         cyc(0, 0, 8'h00);
         chk($sformatf("gap_hi[%0d]", k), E(1, gb[k][7:4], (k < 11), 0, 1, 0, 4'(k + 1), cs));
         if (k < 11)
            for (int g = 0; g < 3; g++) begin
               cyc(0, 0, 8'h00);
               chk($sformatf("gap_wait[%0d]", k), E(0, 4'h0, 1, 0, 1, 0, 4'(k + 1), cs));
            end
      end
      cyc(0, 0, 8'h00);
      chk("gap_done", E(0, 4'h0, 0, 0, 0, 1, 4'd12, cs));
      total++;
      if (got_q.size() != 12) begin
         bad++;
         $display("FAIL gap_readback_len: got %0d required 12", got_q.size());
      end else
         for (int k = 0; k < 12; k++) begin
            total++;
            if (got_q[k] !== gb[k]) begin
               bad++;
               $display("FAIL gap_readback[%0d]: got %h required %h", k, got_q[k], gb[k]);
            end
         end

      // restart during HI of byte 5, then a fresh all-0xFF load (checksum wrap)
      cyc(1, 0, 8'h00);
      cyc(0, 0, 8'h00);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 8'(k + 1));
         cyc(0, 0, 8'h00);
      end
      cyc(0, 1, 8'h06);
      cyc(0, 0, 8'h00);
      chk("restart_in_hi", E(1, 4'h0, 1, 0, 1, 0, 4'd6, 8'd21));
      cyc(1, 1, 8'h77);
      chk("restart_clear", E(0, 4'h0, 0, 1, 1, 0, 4'd0, 8'h00));
      for (int i = 0; i < 26; i++) cyc(0, 1, 8'hFF);
      chk("wrap_done", E(0, 4'h0, 0, 0, 0, 1, 4'd12, 8'hF4));

      // async reset between edges while in LO
      cyc(1, 0, 8'h00);
      cyc(0, 0, 8'h00);
      cyc(0, 1, 8'h5A);
      chk("ar_lo", E(1, 4'hA, 0, 0, 1, 0, 4'd1, 8'h5A));
      s_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar_async", '0);
      @(negedge clk);
      reset = 1'b0;
      cyc(0, 1, 8'h11);
      chk("ar_idle", '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bnn_weight_loader.md
# bnn_weight_loader

Upstream programming sequencer for the 8-8-4 BNN core. Accepts a stream of weight bytes over a valid/ready handshake and converts it into the core's nibble-serial load protocol: `load_en` held high for two consecutive cycles per neuron, low nibble first, then high nibble. Each load sequence begins with a one-cycle pulse that rewinds the core's neuron pointer, then writes exactly `NUM_NEURONS` bytes in neuron order 0..11, then reports done and a checksum.

## Interface
- `NUM_NEURONS`, 12: bytes (neurons) per load sequence.
- `CNT_W`, 4: width of `byte_count`. Must satisfy 2^CNT_W > NUM_NEURONS.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin (or restart) a load sequence.
- `s_valid`  in  1  weight byte valid.
- `s_data`  in  8  weight byte; bit i is the weight for input i.
- `s_ready`  out  1  loader can accept a byte this cycle.
- `load_en`  out  1  to core load-enable pin; registered.
- `load_nibble`  out  4  to core weight pins; registered.
- `bnn_rst`  out  1  one-cycle pulse; OR'd into the core reset to zero its load pointer.
- `busy`  out  1  sequence in progress (CLEAR, WAIT, LO or HI).
- `done`  out  1  all NUM_NEURONS bytes written; held until the next `start` or `reset`.
- `byte_count`  out  CNT_W  bytes accepted in the current sequence.
- `checksum`  out  8  sum mod 256 of the bytes accepted in the current sequence.

## Operation
- States: IDLE, CLEAR, WAIT, LO, HI, DONE. Reset enters IDLE.
- Reset values: every output is 0 and the internal byte register is 0.
- `start` is honoured in every state and has priority over all other events.
  - Next state is CLEAR.
  - `byte_count`, `checksum` and `done` are cleared.
  - Any byte handshaked in the same cycle is discarded and not counted.
- CLEAR: `bnn_rst`=1 for exactly this cycle, `load_en`=0. Next state is WAIT.
- WAIT:
  - `s_ready`=1.
  - On `s_valid`, the loader latches the byte, increments `byte_count`, adds the byte to `checksum`, and goes to LO.
  - With no `s_valid`, it stays in WAIT and `load_en`=0.
- LO: `load_en`=1, `load_nibble`=byte[3:0], `s_ready`=0. Next state is HI.
- HI: `load_en`=1, `load_nibble`=byte[7:4].
  - `s_ready` = (`byte_count` < NUM_NEURONS).
  - If a handshake occurs here, the new byte is latched and the next state is LO (back-to-back, 2 cycles per byte).
  - Otherwise the next state is WAIT if `byte_count` < NUM_NEURONS, else DONE.
- DONE: `done`=1, `s_ready`=0, `load_en`=0.
  - Extra bytes are never accepted, so the core pointer can never run past neuron 11.
- `load_en` is never high for an odd number of consecutive cycles. The only exception is `reset` or `start` arriving in LO, and the `bnn_rst` pulse that follows a `start` realigns the core.
- `checksum` is 8-bit wrap-around addition. `byte_count` saturates at NUM_NEURONS by construction.

## Timing
- `start` sampled at edge t: CLEAR is visible from t, `bnn_rst` is high between t and t+1, and `s_ready` is high from t+1.
- A byte handshaked at edge e produces `load_en`=1 with the low nibble from e, and the high nibble from e+1.
- Sustained throughput is one byte per 2 cycles. A full load with zero gaps takes 1 + 24 cycles from `start` to DONE, plus 1 WAIT cycle.
- `done` rises on the edge after the 12th HI cycle.
- `reset` mid-sequence: all outputs drop to 0 immediately and state returns to IDLE. The core is reset by the same signal at top level.
- Stalls: gaps in `s_valid` insert WAIT cycles with `load_en`=0. The core tolerates these gaps because its nibble phase only advances while `load_en` is high.

## Structure
- Shared package `bnn_pkg` holds:
  - `NUM_NEURONS`=12, `WEIGHT_W`=8 and `NIBBLE_W`=4;
  - the state enum (IDLE, CLEAR, WAIT, LO, HI, DONE).
- The core and any future host interface import the same package.
- Single module, no sub-modules. Checksum and count logic stay inline.

## Test plan
- Back-to-back load: `start`, then bytes 0x00..0x0B with `s_valid` always high.
  - `load_en` is high for 24 consecutive cycles.
  - Nibbles are 0,0,1,0,…,B,0.
  - `done`=1, `byte_count`=12, `checksum`=0x42.
- Gapped load: bytes 0xE0,0x70,… with 3 idle cycles between each.
  - `load_en` pulses in pairs only.
  - `s_ready` is high in every WAIT cycle.
  - The core's readback weights match the bytes written.
- Overflow guard: after `done`, hold `s_valid`=1 with 0xFF for 10 cycles → `s_ready`=0, `load_en`=0, and `byte_count` stays 12.
- Restart mid-load: `start` during the HI cycle of byte 5.
  - Next cycle `bnn_rst`=1, `byte_count`=0, `checksum`=0.
  - A fresh 12-byte load then completes correctly.
- Async reset during LO: assert `reset` between edges → `load_en`, `busy`, `s_ready` and `bnn_rst` go to 0 without waiting for a clock edge, and the state is IDLE.
- Checksum wrap: load 12 bytes of 0xFF → `checksum`=0xF4.
